simplebus_mem_responder: RTL and testbench

SimpleBus responder that serves as the memory end of the bus: it accepts requests from an initiator (cache, DMA, test master) and answers from an internal byte-maskable word memory. It supports single read/write, 4-beat wrapping read bursts and write bursts, with a programmable response latency. It is the target side of the SimpleBus request/response channel and is used as the backing memory in block-level benches and small SoC configurations.

---
 rtl/simplebus_mem_responder_pkg.sv | 38 +++
 rtl/simplebus_mem_responder_if.sv | 34 +++
 rtl/simplebus_mem_array.sv | 32 +++
 rtl/simplebus_mem_responder.sv | 184 ++++++++++++++++++
 tb/tb_simplebus_mem_responder.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/simplebus_mem_responder_pkg.sv
// Shared SimpleBus definitions: field widths, command/response codes, FSM and response-kind enums.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package simplebus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int MASK_W = 8;
    localparam int USER_W = 16;
    localparam int CMD_W  = 4;
    localparam int SIZE_W = 3;

    // Request commands
    localparam logic [CMD_W-1:0] CMD_READ        = 4'b0000;
    localparam logic [CMD_W-1:0] CMD_WRITE       = 4'b0001;
    localparam logic [CMD_W-1:0] CMD_READ_BURST  = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_WRITE_BURST = 4'b0011;
    localparam logic [CMD_W-1:0] CMD_WRITE_LAST  = 4'b0111;

    // Response commands (non-last read beats reuse CMD_READ)
    localparam logic [CMD_W-1:0] RSP_READ_LAST   = 4'b0110;
    localparam logic [CMD_W-1:0] RSP_WRITE_RESP  = 4'b0101;
    localparam logic [CMD_W-1:0] RSP_PROBE_MISS  = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR_BURST,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        RK_READ,
        RK_WRITE,
        RK_PROBE
    } resp_kind_t;

endpackage

// File: rtl/simplebus_mem_responder_if.sv
// SimpleBus request/response channel bundle with initiator (master) and target (slave) views.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the request and the response direction.
interface simplebus_mem_responder_if;
    import simplebus_pkg::*;

    logic              req_ready;
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic [SIZE_W-1:0] req_size;
    logic [CMD_W-1:0]  req_cmd;
    logic [MASK_W-1:0] req_wmask;
    logic [DATA_W-1:0] req_wdata;
    logic [USER_W-1:0] req_user;

    logic              resp_ready;
    logic              resp_valid;
    logic [CMD_W-1:0]  resp_cmd;
    logic [DATA_W-1:0] resp_rdata;
    logic [USER_W-1:0] resp_user;

    modport master (
        input  req_ready, resp_valid, resp_cmd, resp_rdata, resp_user,
        output req_valid, req_addr, req_size, req_cmd, req_wmask, req_wdata, req_user,
               resp_ready
    );

    modport slave (
        output req_ready, resp_valid, resp_cmd, resp_rdata, resp_user,
        input  req_valid, req_addr, req_size, req_cmd, req_wmask, req_wdata, req_user,
               resp_ready
    );

endinterface

// File: rtl/simplebus_mem_array.sv
// Word storage with a byte-masked synchronous write port and an asynchronous read port.
// Latency: write visible on the read port the cycle after the write edge; read is combinational.
// Backpressure: none; every write strobe is committed.
module simplebus_mem_array
    import simplebus_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
    input  logic [MASK_W-1:0]              wmask,
    input  logic [DATA_W-1:0]              wdata,
    input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
    output logic [DATA_W-1:0]              rdata
);

    // Contents are deliberately not reset; they are undefined until written.
    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Byte-lane masked write
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < MASK_W; b++) begin
                if (wmask[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/simplebus_mem_responder.sv
// SimpleBus memory target: single/burst reads and writes against a byte-maskable word array.
// Latency: first response beat LATENCY cycles after the request (or writeLast) is accepted.
// Backpressure: one transaction at a time; req_ready low from accept until the last beat retires.
module simplebus_mem_responder
    import simplebus_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,  // power of two, at least 8
    parameter int LATENCY     = 2,     // at least 1
    parameter int BURST_LEN   = 4      // wrap logic below is built for 4
) (
    input  logic clk,
    input  logic rst,
    simplebus_mem_responder_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int LAT_W = $clog2(LATENCY + 1);

    state_t            state, state_n;
    resp_kind_t        kind_q;
    logic [IDX_W-1:0]  blk_q;       // word index of the accepted address
    logic [USER_W-1:0] user_q;
    logic [LAT_W-1:0]  lat_cnt;
    logic [1:0]        beat_q;      // index of the beat currently presented
    logic [1:0]        last_q;      // index of the final beat
    logic [1:0]        wr_ptr_q;    // next word offset inside the 32-byte block for burst writes

    logic              accept, retire, wr_req;
    logic [IDX_W-1:0]  req_word, mem_waddr, mem_raddr;
    logic [DATA_W-1:0] mem_rdata, ld_data;
    logic [1:0]        ld_idx, rd_off;
    logic [CMD_W-1:0]  ld_cmd;

    // Size and out-of-range address bits do not affect behaviour.
    logic unused_req_bits;
    assign unused_req_bits = ^{bus.req_size, bus.req_addr[2:0], bus.req_addr[ADDR_W-1:3+IDX_W]};

    assign req_word = bus.req_addr[3 +: IDX_W];
    assign accept   = bus.req_valid && bus.req_ready;
    assign retire   = bus.resp_valid && bus.resp_ready;

    // Next-state and memory write-port control
    always_comb begin
        state_n   = state;
        wr_req    = 1'b0;
        mem_waddr = req_word;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (bus.req_cmd)
                        CMD_WRITE: begin
                            wr_req  = 1'b1;
                            state_n = ST_WAIT;
                        end
                        CMD_WRITE_BURST: begin
                            wr_req  = 1'b1;
                            state_n = ST_WR_BURST;
                        end
                        default: state_n = ST_WAIT;
                    endcase
                end
            end
            ST_WR_BURST: begin
                if (accept) begin
                    wr_req    = 1'b1;
                    mem_waddr = {blk_q[IDX_W-1:2], wr_ptr_q};
                    if (bus.req_cmd == CMD_WRITE_LAST) state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_cnt == LAT_W'(1)) state_n = ST_RESP;
            end
            ST_RESP: begin
                if (retire && beat_q == last_q) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Beat to load next: beat 0 when leaving WAIT, otherwise the one after the retiring beat
    always_comb begin
        ld_idx    = (state == ST_RESP) ? beat_q + 2'd1 : 2'd0;
        rd_off    = blk_q[1:0] + ld_idx;   // critical word first, wraps inside the block
        mem_raddr = {blk_q[IDX_W-1:2], rd_off};
        ld_cmd    = RSP_PROBE_MISS;
        ld_data   = '0;
        case (kind_q)
            RK_READ: begin
                ld_cmd  = (ld_idx == last_q) ? RSP_READ_LAST : CMD_READ;
                ld_data = mem_rdata;
            end
            RK_WRITE: ld_cmd = RSP_WRITE_RESP;
            default:  ld_cmd = RSP_PROBE_MISS;
        endcase
    end

    simplebus_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_mem (
        .clk   (clk),
        .we    (wr_req && !rst),
        .waddr (mem_waddr),
        .wmask (bus.req_wmask),
        .wdata (bus.req_wdata),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    // State register, transaction context, latency counter and registered response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            kind_q         <= RK_PROBE;
            blk_q          <= '0;
            user_q         <= '0;
            lat_cnt        <= '0;
            beat_q         <= '0;
            last_q         <= '0;
            wr_ptr_q       <= '0;
            bus.req_ready  <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_cmd   <= '0;
            bus.resp_rdata <= '0;
            bus.resp_user  <= '0;
        end else begin
            state         <= state_n;
            bus.req_ready <= (state_n == ST_IDLE) || (state_n == ST_WR_BURST);
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        blk_q    <= req_word;
                        user_q   <= bus.req_user;
                        lat_cnt  <= LAT_W'(LATENCY);
                        beat_q   <= 2'd0;
                        last_q   <= 2'd0;
                        wr_ptr_q <= req_word[1:0] + 2'd1;
                        case (bus.req_cmd)
                            CMD_READ:        kind_q <= RK_READ;
                            CMD_READ_BURST: begin
                                kind_q <= RK_READ;
                                last_q <= 2'(BURST_LEN - 1);
                            end
                            CMD_WRITE,
                            CMD_WRITE_BURST: kind_q <= RK_WRITE;
                            default:         kind_q <= RK_PROBE;
                        endcase
                    end
                end
                ST_WR_BURST: begin
                    if (accept) begin
                        wr_ptr_q <= wr_ptr_q + 2'd1;
                        if (bus.req_cmd == CMD_WRITE_LAST) lat_cnt <= LAT_W'(LATENCY);
                    end
                end
                ST_WAIT: begin
                    lat_cnt <= lat_cnt - 1'b1;
                    if (lat_cnt == LAT_W'(1)) begin
                        bus.resp_valid <= 1'b1;
                        bus.resp_cmd   <= ld_cmd;
                        bus.resp_rdata <= ld_data;
                        bus.resp_user  <= user_q;
                        beat_q         <= 2'd0;
                    end
                end
                ST_RESP: begin
                    if (retire) begin
                        if (beat_q == last_q) begin
                            bus.resp_valid <= 1'b0;
                            bus.resp_cmd   <= '0;
                            bus.resp_rdata <= '0;
                            bus.resp_user  <= '0;
                        end else begin
                            beat_q         <= beat_q + 2'd1;
                            bus.resp_cmd   <= ld_cmd;
                            bus.resp_rdata <= ld_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_simplebus_mem_responder.sv
// Bench for simplebus_mem_responder: scoreboarded request/response scenarios plus latency variants.
// Latency: checks first beat at LATENCY cycles after accept for LATENCY = 2, 1 and 5.
// Backpressure: exercises stalled response beats and mid-burst reset.
module tb_simplebus_mem_responder;

    localparam int DEPTH = 1024;

    typedef struct {
        logic [3:0]  cmd;
        logic [63:0] data;
        logic [15:0] user;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;

    beat_t       sb[$];
    logic [63:0] mdl [int];

    simplebus_mem_responder_if bus ();
    simplebus_mem_responder_if bus1 ();
    simplebus_mem_responder_if bus5 ();

    simplebus_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2), .BURST_LEN(4))
        dut (.clk(clk), .rst(rst), .bus(bus));
    simplebus_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .BURST_LEN(4))
        dut_l1 (.clk(clk), .rst(rst), .bus(bus1));
    simplebus_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(5), .BURST_LEN(4))
        dut_l5 (.clk(clk), .rst(rst), .bus(bus5));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wi(input logic [31:0] a);
        return int'((a >> 3) & (DEPTH - 1));
    endfunction

    task automatic mdl_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] m);
        logic [63:0] v;
        v = mdl.exists(wi(a)) ? mdl[wi(a)] : 64'hx;
        for (int b = 0; b < 8; b++) if (m[b]) v[b*8 +: 8] = d[b*8 +: 8];
        mdl[wi(a)] = v;
    endtask

    task automatic expect_read(input logic [31:0] a, input logic [15:0] u, input int n);
        int base, off, w;
        base = wi(a) & ~3;
        off  = wi(a) & 3;
        for (int i = 0; i < n; i++) begin
            w = base | ((off + i) & 3);
            sb.push_back('{(i == n - 1) ? 4'h6 : 4'h0, mdl[w], u});
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [3:0] cmd, input logic [31:0] a, input logic [63:0] d,
                        input logic [7:0] m, input logic [15:0] u);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_cmd   = cmd;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_wmask = m;
        bus.req_user  = u;
        bus.req_size  = 3'd3;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 50) $display("FAIL send_ready req_ready=%b required 1 (cmd %h addr %h)", bus.req_ready, cmd, a);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain(input bit toggle, input int exp_lat);
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        bit first = 1'b1;
        int c = 0;
        while (sb.size() > 0 && c < 200) begin
            bus.resp_ready = toggle ? pat[c % 4] : 1'b1;
            if (bus.resp_valid === 1'b1) begin
                if (first && exp_lat >= 0) begin
                    n_checks++;
                    if ((cyc - acc_cyc) !== exp_lat) $display("FAIL latency got %0d required %0d", cyc - acc_cyc, exp_lat);
                    else n_pass++;
                end
                first = 1'b0;
                n_checks++;
                if (bus.resp_cmd !== sb[0].cmd || bus.resp_rdata !== sb[0].data || bus.resp_user !== sb[0].user)
                    $display("FAIL beat cmd=%h rdata=%h user=%h required cmd=%h rdata=%h user=%h",
                             bus.resp_cmd, bus.resp_rdata, bus.resp_user, sb[0].cmd, sb[0].data, sb[0].user);
                else n_pass++;
                n_checks++;
                if (bus.req_ready !== 1'b0) $display("FAIL busy_ready req_ready=%b required 0", bus.req_ready);
                else n_pass++;
                if (bus.resp_ready) void'(sb.pop_front());
            end
            @(negedge clk);
            c++;
        end
        bus.resp_ready = 1'b0;
        n_checks++;
        if (sb.size() != 0) begin
            $display("FAIL drain_timeout beats_left=%0d required 0", sb.size());
            sb.delete();
        end else n_pass++;
        n_checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1)
            $display("FAIL idle_after resp_valid=%b req_ready=%b required 0/1", bus.resp_valid, bus.req_ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0)
            $display("FAIL reset_hs req_ready=%b resp_valid=%b required 0/0", bus.req_ready, bus.resp_valid);
        else n_pass++;
        n_checks++;
        if (bus.resp_cmd !== 4'h0 || bus.resp_rdata !== 64'h0 || bus.resp_user !== 16'h0)
            $display("FAIL reset_out cmd=%h rdata=%h user=%h required zeros", bus.resp_cmd, bus.resp_rdata, bus.resp_user);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b1) $display("FAIL reset_release req_ready=%b required 1", bus.req_ready);
        else n_pass++;
    endtask

    task automatic test_single_write_read();
        mdl_write(32'h100, 64'h1122334455667788, 8'hFF);
        sb.push_back('{4'h5, 64'h0, 16'h00A5});
        send(4'h1, 32'h100, 64'h1122334455667788, 8'hFF, 16'h00A5);
        drain(1'b0, 2);
        expect_read(32'h100, 16'h0011, 1);
        send(4'h0, 32'h100, 64'h0, 8'h00, 16'h0011);
        drain(1'b0, 2);
    endtask

    task automatic test_masked_write();
        mdl_write(32'h108, 64'h0, 8'hFF);
        sb.push_back('{4'h5, 64'h0, 16'h0001});
        send(4'h1, 32'h108, 64'h0, 8'hFF, 16'h0001);
        drain(1'b0, -1);
        mdl_write(32'h108, 64'hFFFFFFFF_DEADBEEF, 8'h0F);
        sb.push_back('{4'h5, 64'h0, 16'h0002});
        send(4'h1, 32'h108, 64'hFFFFFFFF_DEADBEEF, 8'h0F, 16'h0002);
        drain(1'b0, -1);
        sb.push_back('{4'h6, 64'h00000000_DEADBEEF, 16'h0003});
        send(4'h0, 32'h108, 64'h0, 8'h00, 16'h0003);
        drain(1'b0, 2);
    endtask

    task automatic test_burst();
        for (int i = 0; i < 4; i++) mdl_write(32'h200 + 32'(i * 8), 64'(i + 1), 8'hFF);
        sb.push_back('{4'h5, 64'h0, 16'h0B0B});
        send(4'h3, 32'h200, 64'd1, 8'hFF, 16'h0B0B);
        send(4'h3, 32'h200, 64'd2, 8'hFF, 16'h0000);
        send(4'h3, 32'h200, 64'd3, 8'hFF, 16'h0000);
        send(4'h7, 32'h200, 64'd4, 8'hFF, 16'h0000);
        drain(1'b0, 2);
        sb.push_back('{4'h0, 64'd3, 16'h0C0C});
        sb.push_back('{4'h0, 64'd4, 16'h0C0C});
        sb.push_back('{4'h0, 64'd1, 16'h0C0C});
        sb.push_back('{4'h6, 64'd2, 16'h0C0C});
        send(4'h2, 32'h210, 64'h0, 8'h00, 16'h0C0C);
        drain(1'b0, 2);
    endtask

    task automatic test_stall();
        expect_read(32'h208, 16'h5555, 4);
        send(4'h2, 32'h208, 64'h0, 8'h00, 16'h5555);
        drain(1'b1, 2);
    endtask

    task automatic test_probe();
        sb.push_back('{4'h8, 64'h0, 16'h0F0F});
        send(4'h8, 32'h200, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 16'h0F0F);
        drain(1'b0, 2);
        expect_read(32'h200, 16'h0F10, 1);
        send(4'h0, 32'h200, 64'h0, 8'h00, 16'h0F10);
        drain(1'b0, 2);
    endtask

    task automatic test_alias();
        mdl_write(32'h2100, 64'hA1A2A3A4_B1B2B3B4, 8'hFF);
        sb.push_back('{4'h5, 64'h0, 16'h0AAA});
        send(4'h1, 32'h2100, 64'hA1A2A3A4_B1B2B3B4, 8'hFF, 16'h0AAA);
        drain(1'b0, 2);
        expect_read(32'h100, 16'h0AAB, 1);
        send(4'h0, 32'h100, 64'h0, 8'h00, 16'h0AAB);
        drain(1'b0, 2);
    endtask

    task automatic test_wrap_overwrite();
        // Five beats into a four-word block: the fifth wraps onto word 0.
        for (int i = 0; i < 5; i++) mdl_write(32'h400 + 32'((i % 4) * 8), 64'(10 + i), 8'hFF);
        sb.push_back('{4'h5, 64'h0, 16'h0404});
        send(4'h3, 32'h400, 64'd10, 8'hFF, 16'h0404);
        for (int i = 1; i < 4; i++) send(4'h3, 32'h400, 64'(10 + i), 8'hFF, 16'h0);
        send(4'h7, 32'h400, 64'd14, 8'hFF, 16'h0);
        drain(1'b0, 2);
        expect_read(32'h400, 16'h0405, 4);
        send(4'h2, 32'h400, 64'h0, 8'h00, 16'h0405);
        drain(1'b0, 2);
    endtask

    task automatic test_latency_alt();
        int ac;
        int lat1 = -1;
        int lat5 = -1;
        bus1.req_valid = 1'b1; bus1.req_cmd = 4'h1; bus1.req_addr = 32'h0;
        bus1.req_wmask = 8'hFF; bus1.req_wdata = 64'h1; bus1.req_user = 16'h0111;
        bus5.req_valid = 1'b1; bus5.req_cmd = 4'h1; bus5.req_addr = 32'h0;
        bus5.req_wmask = 8'hFF; bus5.req_wdata = 64'h5; bus5.req_user = 16'h0555;
        n_checks++;
        if (bus1.req_ready !== 1'b1 || bus5.req_ready !== 1'b1)
            $display("FAIL alt_ready l1=%b l5=%b required 1/1", bus1.req_ready, bus5.req_ready);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        ac = cyc;
        bus1.req_valid = 1'b0;
        bus5.req_valid = 1'b0;
        bus1.resp_ready = 1'b1;
        bus5.resp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (bus1.resp_valid === 1'b1 && lat1 < 0) begin
                lat1 = cyc - ac;
                n_checks++;
                if (bus1.resp_cmd !== 4'h5 || bus1.resp_user !== 16'h0111)
                    $display("FAIL l1_beat cmd=%h user=%h required 5/0111", bus1.resp_cmd, bus1.resp_user);
                else n_pass++;
            end
            if (bus5.resp_valid === 1'b1 && lat5 < 0) begin
                lat5 = cyc - ac;
                n_checks++;
                if (bus5.resp_cmd !== 4'h5 || bus5.resp_user !== 16'h0555)
                    $display("FAIL l5_beat cmd=%h user=%h required 5/0555", bus5.resp_cmd, bus5.resp_user);
                else n_pass++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (lat1 !== 1) $display("FAIL latency1 got %0d required 1", lat1);
        else n_pass++;
        n_checks++;
        if (lat5 !== 5) $display("FAIL latency5 got %0d required 5", lat5);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        int n = 0;
        for (int i = 0; i < 4; i++) mdl_write(32'h300 + 32'(i * 8), 64'hC0DE_0000 + 64'(i), 8'hFF);
        sb.push_back('{4'h5, 64'h0, 16'h0300});
        send(4'h3, 32'h300, 64'hC0DE_0000, 8'hFF, 16'h0300);
        for (int i = 1; i < 3; i++) send(4'h3, 32'h300, 64'hC0DE_0000 + 64'(i), 8'hFF, 16'h0);
        send(4'h7, 32'h300, 64'hC0DE_0003, 8'hFF, 16'h0);
        drain(1'b0, 2);
        send(4'h2, 32'h300, 64'h0, 8'h00, 16'h0301);
        bus.resp_ready = 1'b1;
        while (bus.resp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 64'hC0DE_0000)
            $display("FAIL mid_beat0 valid=%b rdata=%h required 1/00000000c0de0000", bus.resp_valid, bus.resp_rdata);
        else n_pass++;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0)
            $display("FAIL mid_reset resp_valid=%b req_ready=%b required 0/0", bus.resp_valid, bus.req_ready);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b1) $display("FAIL mid_release req_ready=%b required 1", bus.req_ready);
        else n_pass++;
        expect_read(32'h308, 16'h0302, 1);
        send(4'h0, 32'h308, 64'h0, 8'h00, 16'h0302);
        drain(1'b0, 2);
    endtask

    initial begin
        bus.req_valid = 1'b0;  bus.req_addr = '0;  bus.req_size = '0;  bus.req_cmd = '0;
        bus.req_wmask = '0;    bus.req_wdata = '0; bus.req_user = '0;  bus.resp_ready = 1'b0;
        bus1.req_valid = 1'b0; bus1.req_addr = '0; bus1.req_size = '0; bus1.req_cmd = '0;
        bus1.req_wmask = '0;   bus1.req_wdata = '0; bus1.req_user = '0; bus1.resp_ready = 1'b0;
        bus5.req_valid = 1'b0; bus5.req_addr = '0; bus5.req_size = '0; bus5.req_cmd = '0;
        bus5.req_wmask = '0;   bus5.req_wdata = '0; bus5.req_user = '0; bus5.resp_ready = 1'b0;

        test_reset();
        test_single_write_read();
        test_masked_write();
        test_burst();
        test_stall();
        test_probe();
        test_alias();
        test_wrap_overwrite();
        test_latency_alt();
        test_mid_reset();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
